// File: rtl/aes_ctrl_pkg.sv
// Shared constants for the AES control slice: S-box share FSM encoding,
// requester ids, engine direction values and the datapath width.
package aes_ctrl_pkg;

   localparam int AES_DATA_W = 128;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic REQ_RND = 1'b0;
   localparam logic REQ_KEY = 1'b1;

   localparam logic EN_FWD = 1'b1;
   localparam logic EN_INV = 1'b0;

endpackage

// File: rtl/sbox_rr_arb.sv
// Two-way round-robin arbiter for the shared S-box: on a tie the requester
// that did not win last time is granted; the history only moves on a grant.
module sbox_rr_arb
   import aes_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_grant_en,
   output logic o_grant_valid,
   output logic o_grant_id
);

   logic r_last_grant;
   logic w_grant_id;

   always_comb begin
      w_grant_id = REQ_RND;
      if (i_req0 && i_req1) begin
         w_grant_id = ~r_last_grant;
      end else if (i_req1) begin
         w_grant_id = REQ_KEY;
      end
   end

   assign o_grant_valid = i_grant_en && (i_req0 || i_req1);
   assign o_grant_id    = w_grant_id;

   // Reset history to the key requester so the round datapath wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= REQ_KEY;
      end else if (o_grant_valid) begin
         r_last_grant <= w_grant_id;
      end
   end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares one SubBytes engine between the round datapath and key expansion.
// Optional watchdog on the engine wait is enabled by defining SBOX_TIMEOUT_EN.
module sbox_share_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int DATA_W  = AES_DATA_W,
   parameter int TIMEOUT = 64
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic [DATA_W-1:0] r0_data,
   input  logic              r0_en_de,
   output logic              r0_done,
   output logic [DATA_W-1:0] r0_result,
   input  logic              r1_req,
   input  logic [DATA_W-1:0] r1_data,
   output logic              r1_done,
   output logic [DATA_W-1:0] r1_result,
   output logic [DATA_W-1:0] sb_data_in,
   output logic              sb_start_in,
   output logic              sb_en_de,
   input  logic [DATA_W-1:0] sb_data_out,
   input  logic              sb_ready_out,
   output logic              busy,
   output logic              err
);

   logic [1:0]        r_state;
   logic              r_gnt_id;
   logic [DATA_W-1:0] r_sb_data_in;
   logic              r_sb_en_de;
   logic [DATA_W-1:0] r_r0_result;
   logic [DATA_W-1:0] r_r1_result;
   logic              w_grant_valid;
   logic              w_grant_id;
   logic              w_timeout;

   sbox_rr_arb u_arb (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req0        (r0_req),
      .i_req1        (r1_req),
      .i_grant_en    (r_state == ST_IDLE),
      .o_grant_valid (w_grant_valid),
      .o_grant_id    (w_grant_id)
   );

   // Key expansion only ever needs the forward S-box, so its direction is fixed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_gnt_id     <= REQ_RND;
         r_sb_data_in <= '0;
         r_sb_en_de   <= EN_INV;
         r_r0_result  <= '0;
         r_r1_result  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  r_gnt_id     <= w_grant_id;
                  r_sb_data_in <= (w_grant_id == REQ_RND) ? r0_data : r1_data;
                  r_sb_en_de   <= (w_grant_id == REQ_RND) ? r0_en_de : EN_FWD;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (sb_ready_out || w_timeout) begin
                  if (r_gnt_id == REQ_RND) begin
                     r_r0_result <= sb_ready_out ? sb_data_out : '0;
                  end else begin
                     r_r1_result <= sb_ready_out ? sb_data_out : '0;
                  end
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SBOX_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_abort;

   // Abort lands in DONE the cycle after the limit, so err lines up with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
         r_abort    <= 1'b0;
      end else begin
         r_abort <= w_timeout;
         if ((r_state == ST_WAIT) && !sb_ready_out && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end else begin
            r_wait_cnt <= '0;
         end
      end
   end

   assign w_timeout = (r_state == ST_WAIT) && !sb_ready_out &&
                      (r_wait_cnt == CNT_W'(TIMEOUT - 1));
   assign err       = r_abort;
`else
   logic [7:0] w_unused_timeout;
   assign w_unused_timeout = 8'(TIMEOUT);
   assign w_timeout        = 1'b0;
   assign err              = 1'b0;
`endif

   assign sb_data_in  = r_sb_data_in;
   assign sb_en_de    = r_sb_en_de;
   assign sb_start_in = (r_state == ST_ISSUE);
   assign busy        = (r_state != ST_IDLE);
   assign r0_done     = (r_state == ST_DONE) && (r_gnt_id == REQ_RND);
   assign r1_done     = (r_state == ST_DONE) && (r_gnt_id == REQ_KEY);
   assign r0_result   = r_r0_result;
   assign r1_result   = r_r1_result;

endmodule
